// File: rtl/jseq_pkg.sv
// rtl/jseq_pkg.sv - shared types, constants and helpers for the Johnson step sequencer
//
// Purpose : state and status encodings, rotation direction constants, the
//           ring geometry and the Johnson next-code function shared by the
//           sequencer and its code decoder.
// Ports   : none (package).
package jseq_pkg;

   localparam int JSEQ_WIDTH = 4;
   localparam int IDX_W      = $clog2(2 * JSEQ_WIDTH);

   typedef enum logic [2:0] {
      IDLE,
      PLAN,
      STEP,
      CHECK,
      RESP
   } state_t;

   typedef enum logic [1:0] {
      OK          = 2'b00,
      BAD_TARGET  = 2'b01,
      BAD_CURRENT = 2'b10,
      DESYNC      = 2'b11
   } status_t;

   localparam logic FWD = 1'b0;
   localparam logic REV = 1'b1;

   // FWD shifts left inserting ~msb; REV shifts right inserting ~lsb.
   function automatic logic [JSEQ_WIDTH-1:0] johnson_next(
      input logic [JSEQ_WIDTH-1:0] code,
      input logic                  dir
   );
      if (dir == FWD)
         return {code[JSEQ_WIDTH-2:0], ~code[JSEQ_WIDTH-1]};
      else
         return {~code[0], code[JSEQ_WIDTH-1:1]};
   endfunction

endpackage

// File: rtl/johnson_code_decoder.sv
// rtl/johnson_code_decoder.sv - maps a Johnson code to its ring index
//
// Purpose : combinational decode of a WIDTH-bit Johnson code into a validity
//           flag and its index (number of FWD steps from the reset code 10..0).
// Ports   : code  in  WIDTH  code to decode
//           valid out 1      code is one of the 2*WIDTH legal states
//           index out IW     ring index, 0 when invalid
module johnson_code_decoder #(
   parameter int WIDTH = 4,
   parameter int IW    = $clog2(2 * WIDTH)
) (
   input  logic [WIDTH-1:0] code,
   output logic             valid,
   output logic [IW-1:0]    index
);

   logic [WIDTH-1:0] walk;

   // Walk the ring from the reset code and match each legal state.
   always_comb begin
      valid = 1'b0;
      index = '0;
      walk  = {1'b1, {(WIDTH-1){1'b0}}};
      for (int k = 0; k < 2 * WIDTH; k++) begin
         if (code == walk) begin
            valid = 1'b1;
            index = IW'(k);
         end
         walk = {walk[WIDTH-2:0], ~walk[WIDTH-1]};
      end
   end

endmodule

// File: rtl/johnson_step_sequencer.sv
// rtl/johnson_step_sequencer.sv - moves a Johnson counter to a commanded code by the shorter path
//
// Purpose : accepts a target code, plans direction and step count, pulses the
//           counter enable once per step, verifies each step against count
//           feedback and returns a status plus executed step count.
// Option  : JSEQ_SETTLE_WAIT_EN - CHECK waits up to SETTLE_MAX cycles for the
//           feedback to reach the expected code instead of a single-shot compare.
// Ports   : clk, rst_n                 clock, async active-low reset
//           cmd_valid/cmd_ready/cmd_target   command handshake and target code
//           rsp_valid/rsp_ready/rsp_status/rsp_steps  response handshake
//           busy                       high outside IDLE
//           cnt_enable/cnt_up_down     drive to the counter
//           cnt_count                  counter feedback
module johnson_step_sequencer
   import jseq_pkg::*;
#(
   parameter int WIDTH      = JSEQ_WIDTH,
   parameter int SETTLE_MAX = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [WIDTH-1:0]           cmd_target,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [1:0]                 rsp_status,
   output logic [$clog2(WIDTH+1)-1:0] rsp_steps,
   output logic                       busy,
   output logic                       cnt_enable,
   output logic                       cnt_up_down,
   input  logic [WIDTH-1:0]           cnt_count
);

   localparam int SW   = $clog2(WIDTH + 1);
   localparam int RING = 2 * WIDTH;

   state_t           state;
   logic [WIDTH-1:0] tgt_code;
   logic [WIDTH-1:0] cur_code;
   logic [WIDTH-1:0] exp_code;
   logic [SW-1:0]    steps;
   logic [SW-1:0]    n_steps;
   logic [SW-1:0]    steps_inc;
`ifdef JSEQ_SETTLE_WAIT_EN
   logic [$clog2(SETTLE_MAX+1)-1:0] settle;
`endif

   logic             tgt_valid;
   logic             cur_valid;
   logic [IDX_W-1:0] tgt_idx;
   logic [IDX_W-1:0] cur_idx;
   logic [IDX_W:0]   diff;
   logic [IDX_W-1:0] d;

   johnson_code_decoder #(.WIDTH(WIDTH), .IW(IDX_W)) u_tgt_dec (
      .code  (tgt_code),
      .valid (tgt_valid),
      .index (tgt_idx)
   );

   johnson_code_decoder #(.WIDTH(WIDTH), .IW(IDX_W)) u_cur_dec (
      .code  (cnt_count),
      .valid (cur_valid),
      .index (cur_idx)
   );

   // Forward distance on the ring; one extra bit so the wrap never underflows.
   always_comb begin
      diff = {1'b0, tgt_idx} + (IDX_W+1)'(RING) - {1'b0, cur_idx};
      if (diff >= (IDX_W+1)'(RING))
         diff = diff - (IDX_W+1)'(RING);
      d = diff[IDX_W-1:0];
   end

   assign steps_inc = steps + SW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cmd_ready   <= 1'b0;
         busy        <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_status  <= 2'b00;
         rsp_steps   <= '0;
         cnt_enable  <= 1'b0;
         cnt_up_down <= 1'b0;
         tgt_code    <= '0;
         cur_code    <= '0;
         exp_code    <= '0;
         steps       <= '0;
         n_steps     <= '0;
`ifdef JSEQ_SETTLE_WAIT_EN
         settle      <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (cmd_ready && cmd_valid) begin
                  tgt_code  <= cmd_target;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  state     <= PLAN;
               end else begin
                  cmd_ready <= 1'b1;
               end
            end
            PLAN: begin
               steps    <= '0;
               cur_code <= cnt_count;
               if (!tgt_valid) begin
                  rsp_status <= BAD_TARGET;
                  rsp_steps  <= '0;
                  rsp_valid  <= 1'b1;
                  state      <= RESP;
               end else if (!cur_valid) begin
                  rsp_status <= BAD_CURRENT;
                  rsp_steps  <= '0;
                  rsp_valid  <= 1'b1;
                  state      <= RESP;
               end else if (d == '0) begin
                  rsp_status <= OK;
                  rsp_steps  <= '0;
                  rsp_valid  <= 1'b1;
                  state      <= RESP;
               end else begin
                  // A half-ring tie resolves FWD.
                  if (d <= IDX_W'(WIDTH)) begin
                     cnt_up_down <= FWD;
                     n_steps     <= SW'(d);
                  end else begin
                     cnt_up_down <= REV;
                     n_steps     <= SW'(RING - int'(d));
                  end
                  cnt_enable <= 1'b1;
                  state      <= STEP;
               end
            end
            STEP: begin
               cnt_enable <= 1'b0;
               exp_code   <= johnson_next(cur_code, cnt_up_down);
`ifdef JSEQ_SETTLE_WAIT_EN
               settle     <= '0;
`endif
               state      <= CHECK;
            end
            CHECK: begin
               if (cnt_count == exp_code) begin
                  cur_code <= exp_code;
                  steps    <= steps_inc;
                  if (steps_inc == n_steps) begin
                     rsp_status <= OK;
                     rsp_steps  <= steps_inc;
                     rsp_valid  <= 1'b1;
                     state      <= RESP;
                  end else begin
                     cnt_enable <= 1'b1;
                     state      <= STEP;
                  end
               end else begin
`ifdef JSEQ_SETTLE_WAIT_EN
                  if (settle == $bits(settle)'(SETTLE_MAX - 1)) begin
                     rsp_status <= DESYNC;
                     rsp_steps  <= steps;
                     rsp_valid  <= 1'b1;
                     state      <= RESP;
                  end else begin
                     settle <= settle + 1'b1;
                  end
`else
                  rsp_status <= DESYNC;
                  rsp_steps  <= steps;
                  rsp_valid  <= 1'b1;
                  state      <= RESP;
`endif
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  busy      <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_johnson_step_sequencer.sv
// tb/tb_johnson_step_sequencer.sv - scoreboard bench for johnson_step_sequencer
module tb_johnson_step_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [3:0] cmd_target = 4'b0000;
   logic       rsp_valid;
   logic       rsp_ready = 1'b1;
   logic [1:0] rsp_status;
   logic [2:0] rsp_steps;
   logic       busy;
   logic       cnt_enable;
   logic       cnt_up_down;
   logic [3:0] cnt_count;

   johnson_step_sequencer #(.WIDTH(4), .SETTLE_MAX(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_target (cmd_target),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_status (rsp_status),
      .rsp_steps  (rsp_steps),
      .busy       (busy),
      .cnt_enable (cnt_enable),
      .cnt_up_down(cnt_up_down),
      .cnt_count  (cnt_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] status;
      int         steps;
      int         lat;
      int         pulses;
      logic       dir;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   acc_edge = 0;
   int   acc_count = 0;
   int   hs_edge = 0;
   int   pulses = 0;
   logic last_dir = 1'b0;

   // Counter model: forced loads and a freeze point for desync injection.
   logic       force_req = 1'b0;
   logic [3:0] force_val = 4'b1000;
   int         moves = 0;
   int         freeze_at = 1000000;

   function automatic void chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   initial begin
      cnt_count = 4'b1000;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n)
            cnt_count <= 4'b1000;
         else if (force_req)
            cnt_count <= force_val;
         else if (cnt_enable && moves < freeze_at) begin
            if (cnt_up_down)
               cnt_count <= {~cnt_count[0], cnt_count[3:1]};
            else
               cnt_count <= {cnt_count[2:0], ~cnt_count[3]};
            moves <= moves + 1;
         end
      end
   end

   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   // Monitor: tracks acceptance, enable pulses and pops on each response handshake.
   initial begin
      logic       prev_valid;
      logic [1:0] held_st;
      logic [2:0] held_steps;
      int         lat;
      exp_t       e;
      prev_valid = 1'b0;
      held_st    = 2'b00;
      held_steps = 3'd0;
      lat        = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_valid = 1'b0;
            continue;
         end
         if (cnt_enable) begin
            pulses++;
            last_dir = cnt_up_down;
         end
         if (cmd_valid && cmd_ready) begin
            acc_edge = cyc + 1;
            pulses   = 0;
            acc_count++;
         end
         if (rsp_valid) begin
            if (!prev_valid) begin
               lat        = cyc + 1 - acc_edge;
               held_st    = rsp_status;
               held_steps = rsp_steps;
            end else begin
               chk("hold_status", int'(rsp_status), int'(held_st));
               chk("hold_steps", int'(rsp_steps), int'(held_steps));
            end
            if (rsp_ready) begin
               hs_edge = cyc + 1;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_rsp: status %0d steps %0d with no command pending",
                           rsp_status, rsp_steps);
               end else begin
                  e = exp_q.pop_front();
                  chk("status", int'(rsp_status), int'(e.status));
                  chk("steps", int'(rsp_steps), e.steps);
                  chk("latency", lat, e.lat);
                  chk("enable_pulses", pulses, e.pulses);
                  if (e.pulses > 0)
                     chk("direction", int'(last_dir), int'(e.dir));
               end
            end
         end
         prev_valid = rsp_valid && !rsp_ready;
      end
   end

   task automatic push_exp(input logic [1:0] st, input int steps, input int lat,
                           input int np, input logic dir);
      exp_t e;
      e.status = st;
      e.steps  = steps;
      e.lat    = lat;
      e.pulses = np;
      e.dir    = dir;
      exp_q.push_back(e);
   endtask

   task automatic send(input logic [3:0] tgt, input bit drop);
      int  n0;
      bit  ok;
      n0 = acc_count;
      ok = 1'b0;
      cmd_valid  = 1'b1;
      cmd_target = tgt;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk);
         #1;
         if (acc_count != n0) begin
            ok = 1'b1;
            break;
         end
      end
      chk("cmd_accepted", int'(ok), 1);
      if (drop) begin
         cmd_valid  = 1'b0;
         cmd_target = 4'b0101;
      end
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         if (exp_q.size() == 0 && !busy && !rsp_valid) begin
            ok = 1'b1;
            break;
         end
      end
      chk("drained", int'(ok), 1);
   endtask

   task automatic issue(input logic [3:0] tgt, input logic [1:0] st, input int steps,
                        input int lat, input int np, input logic dir);
      push_exp(st, steps, lat, np, dir);
      send(tgt, 1'b1);
      wait_idle();
   endtask

   task automatic load_count(input logic [3:0] v);
      force_val = v;
      force_req = 1'b1;
      @(posedge clk);
      #1;
      force_req = 1'b0;
   endtask

   initial begin
      bit ok;
      int en_seen;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_cmd_ready", int'(cmd_ready), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_rsp_valid", int'(rsp_valid), 0);
      chk("rst_cnt_enable", int'(cnt_enable), 0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("idle_cmd_ready", int'(cmd_ready), 1);

      // Half-ring tie from reset code goes FWD in four steps.
      issue(4'b0111, 2'b00, 4, 10, 4, 1'b0);
      // Back to index 0, again a tie.
      issue(4'b1000, 2'b00, 4, 10, 4, 1'b0);
      // Index 7 from index 0: one REV step.
      issue(4'b1100, 2'b00, 1, 4, 1, 1'b1);
      // Illegal target.
      issue(4'b0101, 2'b01, 0, 2, 0, 1'b0);
      // Already at target.
      issue(4'b1100, 2'b00, 0, 2, 0, 1'b0);
      // Wrap 7 -> 0 -> 1 forward.
      issue(4'b0000, 2'b00, 2, 6, 2, 1'b0);
      // Illegal current code.
      load_count(4'b0101);
      issue(4'b0000, 2'b10, 0, 2, 0, 1'b0);
      load_count(4'b1000);
      // Counter freezes after its first step of a 3-step move.
      freeze_at = moves + 1;
      issue(4'b0011, 2'b11, 1, 6, 2, 1'b0);
      freeze_at = 1000000;

      // Stalled response with a second command waiting behind it.
      rsp_ready = 1'b0;
      push_exp(2'b00, 1, 4, 1, 1'b0);
      push_exp(2'b00, 1, 4, 1, 1'b0);
      send(4'b0001, 1'b0);
      cmd_target = 4'b0011;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (rsp_valid) begin
            ok = 1'b1;
            break;
         end
      end
      chk("rsp_seen", int'(ok), 1);
      repeat (5) @(posedge clk);
      #1;
      chk("no_accept_while_busy", int'(cmd_ready), 0);
      rsp_ready = 1'b1;
      send(4'b0011, 1'b1);
      chk("accept_after_rsp", int'(acc_edge - hs_edge >= 1), 1);
      wait_idle();

      // Reset during the second step of a 4-step move.
      send(4'b1100, 1'b1);
      en_seen = 0;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (cnt_enable) en_seen++;
         if (en_seen == 2) begin
            ok = 1'b1;
            break;
         end
      end
      chk("second_step_seen", int'(ok), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_cnt_enable", int'(cnt_enable), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_rsp_valid", int'(rsp_valid), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("post_rst_cmd_ready", int'(cmd_ready), 1);
      chk("post_rst_rsp_valid", int'(rsp_valid), 0);
      chk("post_rst_busy", int'(busy), 0);
      // Counter is back at its reset code, so this is a zero-step move.
      issue(4'b1000, 2'b00, 0, 2, 0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
